disp_sched: RTL and testbench
=============================

DISP_SCHED -- requirements
Module: disp_sched

Interface
REQ-001 Parameter DWELL, default 2048, SHALL be the grant dwell time in clk cycles, with a legal range of 1..65535.
REQ-002 clk  input  1  SHALL be the system clock; all state changes on its rising edge.
REQ-003 rst_n  input  1  SHALL be the asynchronous, active-low reset.
REQ-004 req  input  4  SHALL carry per-source display requests; bit i belongs to source i.
REQ-005 data0, data1, data2, data3  input  32 each ([32:1])  SHALL carry the per-source display words; bit 32 is the leftmost nibble's MSB.
REQ-006 gnt  output  4  SHALL be the one-hot grant, or 0 when idle.
REQ-007 owner  output  2  SHALL be the index of the current/last owner.
REQ-008 disp_data  output  32 ([32:1])  SHALL be the registered word driven to the 8-digit scanner.
REQ-009 busy  output  1  SHALL be 1 exactly when gnt!=0.

Function
REQ-010 The FSM SHALL have two states: IDLE and SHOW; dwell counter cnt SHALL be 16 bits.
REQ-011 IDLE, req==0 -> SHALL stay in IDLE; gnt=0; disp_data per REQ-020.
REQ-012 IDLE, req!=0 at edge t -> after t: state=SHOW, winner per REQ-015, gnt=onehot(winner), owner=winner, disp_data=data[winner], cnt=DWELL-1.
REQ-013 SHOW, req[owner]=1 and cnt!=0 -> SHALL decrement cnt; disp_data<=data[owner] every edge (1-cycle live tracking).
REQ-014 SHOW with cnt==0 or req[owner]==0 -> SHALL re-arbitrate on that edge: any req set -> load winner as in REQ-012, same edge, no idle gap; none -> IDLE, gnt=0, owner held.
REQ-015 Round-robin: search SHALL start at owner+1 mod 4, ascending, wrapping; the current owner has lowest priority; with only the owner requesting it SHALL be re-granted (fresh dwell).
REQ-016 A granted source SHALL hold gnt for exactly DWELL cycles when it keeps req high and the dwell expires; an owner dropping req SHALL release on the next edge.
REQ-017 Requests arriving mid-dwell SHALL NOT pre-empt; they SHALL be served at the next arbitration.
REQ-018 With DWELL=1, every SHOW edge SHALL be an arbitration edge.
REQ-019 Non-owner data changes SHALL NOT affect disp_data.

Reset
REQ-020 rst_n=0 SHALL immediately force state=IDLE, gnt=0, owner=3 (so source 0 wins first), cnt=0, disp_data=32'h0, busy=0, regardless of any in-flight dwell.
REQ-021 After reset release, the first arbitration SHALL occur on the first rising edge with rst_n=1 and req!=0.

Configuration
REQ-022 Macro DISP_SCHED_IDLE_BLANK_EN.
REQ-023 Defined: on every IDLE entry disp_data SHALL be cleared to 32'h0 (display shows 00000000).
REQ-024 Undefined: disp_data SHALL hold the last owner's final word while IDLE.

Verification (DWELL=4 unless noted)
REQ-025 Reset mid-SHOW: gnt=4'b0010, rst_n pulsed low -> same cycle gnt=0, disp_data=0, busy=0; first grant after release is to source 0 if req=4'b1111.
REQ-026 req=4'b1111 held, data_i=32'h1111_1111*(i+1) -> grants 0,1,2,3,0 for 4 cycles each; disp_data follows 11111111, 22222222, ...
REQ-027 req=4'b0100 only, held 12 cycles -> gnt=4'b0100 continuous, no gap; cnt reloads every 4 cycles.
REQ-028 Owner 1 drops req at dwell cycle 2, req[3] high -> next edge gnt=4'b1000, owner=3.
REQ-029 Owner 2 alone, data2 increments each cycle -> disp_data equals data2 delayed by one cycle.
REQ-030 Last req dropped, data was 32'hDEAD_BEEF -> disp_data=0 with DISP_SCHED_IDLE_BLANK_EN, else stays 32'hDEAD_BEEF; gnt=0, busy=0.

Source files
------------

// File: rtl/disp_sched.sv
// Round-robin display scheduler: grants one of four sources for DWELL cycles and forwards its word.
// Optional macro DISP_SCHED_IDLE_BLANK_EN clears disp_data whenever the scheduler falls back to IDLE.
module disp_sched #(
  parameter int unsigned DWELL = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  input  logic [32:1] data0,
  input  logic [32:1] data1,
  input  logic [32:1] data2,
  input  logic [32:1] data3,
  output logic [3:0]  gnt,
  output logic [1:0]  owner,
  output logic [32:1] disp_data,
  output logic        busy
);

  typedef enum logic {IDLE, SHOW} state_t;

  localparam logic [15:0] RELOAD = 16'(DWELL - 1);

  state_t      state, state_nx;
  logic [15:0] cnt, cnt_nx;
  logic [3:0]  gnt_nx;
  logic [1:0]  owner_nx, winner, idx;
  logic [32:1] disp_nx, win_data, own_data;
  logic        arb;

  // Scan from owner+3 down to owner+1 so the nearest successor wins; owner+4 (itself) is last resort.
  always_comb begin
    winner = owner;
    idx    = owner;
    for (int unsigned k = 4; k >= 1; k--) begin
      idx = owner + 2'(k);
      if (req[idx]) winner = idx;
    end
  end

  always_comb begin
    case (winner)
      2'd0:    win_data = data0;
      2'd1:    win_data = data1;
      2'd2:    win_data = data2;
      default: win_data = data3;
    endcase
    case (owner)
      2'd0:    own_data = data0;
      2'd1:    own_data = data1;
      2'd2:    own_data = data2;
      default: own_data = data3;
    endcase
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    gnt_nx   = gnt;
    owner_nx = owner;
    disp_nx  = disp_data;
    arb      = (state == IDLE) || (cnt == '0) || !req[owner];
    if (arb) begin
      if (|req) begin
        state_nx = SHOW;
        owner_nx = winner;
        gnt_nx   = 4'b0001 << winner;
        cnt_nx   = RELOAD;
        disp_nx  = win_data;
      end else begin
        state_nx = IDLE;
        gnt_nx   = '0;
        cnt_nx   = '0;
`ifdef DISP_SCHED_IDLE_BLANK_EN
        disp_nx  = '0;
`endif
      end
    end else begin
      cnt_nx  = cnt - 16'd1;
      disp_nx = own_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      gnt       <= '0;
      owner     <= 2'd3;
      disp_data <= '0;
    end else begin
      state     <= state_nx;
      cnt       <= cnt_nx;
      gnt       <= gnt_nx;
      owner     <= owner_nx;
      disp_data <= disp_nx;
    end
  end

  assign busy = |gnt;

endmodule

// File: tb/tb_disp_sched.sv
// Self-checking bench for disp_sched: DWELL=4 and DWELL=1 instances against a grant-level model.
module tb_disp_sched;

  logic             clk;
  logic             rst_n;
  logic [3:0]       req;
  logic [3:0][31:0] dv;
  logic [3:0]       gnt4, gnt1;
  logic [1:0]       own4, own1;
  logic [31:0]      disp4, disp1;
  logic             busy4, busy1;

  int checks = 0;
  int errors = 0;

  disp_sched #(.DWELL(4)) u4 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(dv[0]), .data1(dv[1]), .data2(dv[2]), .data3(dv[3]),
    .gnt(gnt4), .owner(own4), .disp_data(disp4), .busy(busy4)
  );

  disp_sched #(.DWELL(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req),
    .data0(dv[0]), .data1(dv[1]), .data2(dv[2]), .data3(dv[3]),
    .gnt(gnt1), .owner(own1), .disp_data(disp1), .busy(busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: who holds the display, and how many granted cycles remain including the current one.
  typedef struct {
    bit          act;
    logic [1:0]  own;
    int          left;
    logic [31:0] disp;
  } ms_t;

  ms_t m4, m1, mrst;

  initial begin
    mrst.act = 1'b0; mrst.own = 2'd3; mrst.left = 0; mrst.disp = '0;
  end

  function automatic ms_t mstep(ms_t s, logic [3:0] r, logic [3:0][31:0] d, int dw);
    ms_t n = s;
    int  w = -1;
    if (s.act && s.left > 1 && r[s.own]) begin
      n.left = s.left - 1;
      n.disp = d[s.own];
    end else if (r != 4'b0) begin
      for (int k = 1; k <= 4; k++)
        if (w < 0 && r[(int'(s.own) + k) % 4]) w = (int'(s.own) + k) % 4;
      n.act  = 1'b1;
      n.own  = 2'(w);
      n.left = dw;
      n.disp = d[w];
    end else begin
      n.act = 1'b0;
`ifdef DISP_SCHED_IDLE_BLANK_EN
      n.disp = '0;
`endif
    end
    return n;
  endfunction

  function automatic logic [3:0] mgnt(ms_t s);
    return s.act ? 4'(1 << s.own) : 4'b0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m4 <= mrst;
      m1 <= mrst;
    end else begin
      m4 <= mstep(m4, req, dv, 4);
      m1 <= mstep(m1, req, dv, 1);
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("u4.gnt",   64'(gnt4),  64'(mgnt(m4)));
    chk("u4.owner", 64'(own4),  64'(m4.own));
    chk("u4.disp",  64'(disp4), 64'(m4.disp));
    chk("u4.busy",  64'(busy4), 64'(m4.act));
    chk("u1.gnt",   64'(gnt1),  64'(mgnt(m1)));
    chk("u1.owner", 64'(own1),  64'(m1.own));
    chk("u1.disp",  64'(disp1), 64'(m1.disp));
    chk("u1.busy",  64'(busy1), 64'(m1.act));
  end

  logic [31:0] prev;
  logic [31:0] idle_exp;

  initial begin
    rst_n = 1'b0;
    req   = 4'b0;
    dv    = '0;
    repeat (2) @(negedge clk);
    chk("rst.gnt",   64'(gnt4),  64'h0);
    chk("rst.owner", 64'(own4),  64'h3);
    chk("rst.disp",  64'(disp4), 64'h0);
    chk("rst.busy",  64'(busy4), 64'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle.gnt", 64'(gnt4), 64'h0);

    // Full rotation with all sources requesting.
    for (int i = 0; i < 4; i++) dv[i] = 32'h1111_1111 * (i + 1);
    req = 4'b1111;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("rot.gnt",  64'(gnt4),  64'(1 << ((c / 4) % 4)));
      chk("rot.disp", 64'(disp4), 64'(32'h1111_1111 * (((c / 4) % 4) + 1)));
      if (c < 4) chk("d1.gnt", 64'(gnt1), 64'(1 << c));
    end

    // Lone requester: continuous re-grant, display tracks data2 one cycle late.
    req  = 4'b0100;
    prev = dv[2];
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      chk("solo.gnt",  64'(gnt4),  64'h4);
      chk("solo.disp", 64'(disp4), 64'(prev));
      dv[2] = dv[2] + 32'd1;
      prev  = dv[2];
    end

    // Last request drops.
    dv[2] = 32'hDEAD_BEEF;
    @(negedge clk);
    chk("drop.pre", 64'(disp4), 64'hDEAD_BEEF);
    req = 4'b0;
`ifdef DISP_SCHED_IDLE_BLANK_EN
    idle_exp = 32'h0;
`else
    idle_exp = 32'hDEAD_BEEF;
`endif
    repeat (2) begin
      @(negedge clk);
      chk("drop.gnt",   64'(gnt4),  64'h0);
      chk("drop.busy",  64'(busy4), 64'h0);
      chk("drop.owner", 64'(own4),  64'h2);
      chk("drop.disp",  64'(disp4), 64'(idle_exp));
    end

    // Owner 1 releases mid-dwell while source 3 waits.
    req = 4'b0010;
    @(negedge clk);
    chk("rel.gnt1", 64'(gnt4), 64'h2);
    req = 4'b1010;
    @(negedge clk);
    chk("rel.nopre", 64'(gnt4), 64'h2);
    req = 4'b1000;
    @(negedge clk);
    chk("rel.gnt3",  64'(gnt4), 64'h8);
    chk("rel.owner", 64'(own4), 64'h3);

    // Asynchronous reset during a grant.
    req = 4'b0010;
    @(negedge clk);
    chk("ar.pre", 64'(gnt4), 64'h2);
    req = 4'b1111;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("ar.gnt",   64'(gnt4),  64'h0);
    chk("ar.disp",  64'(disp4), 64'h0);
    chk("ar.busy",  64'(busy4), 64'h0);
    chk("ar.owner", 64'(own4),  64'h3);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("ar.first", 64'(gnt4),  64'h1);
    chk("ar.fdisp", 64'(disp4), 64'h1111_1111);

    // Randomized traffic, with occasional asynchronous resets.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 499) == 0) rst_n = 1'b0;
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      if ($urandom_range(0, 7) == 0) req = 4'b0;
      if ($urandom_range(0, 1) == 0) dv[$urandom_range(0, 3)] = $urandom;
    end
    @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
